// File: rtl/grid_video_pkg.sv
// Shared constants and types for the grid video renderer.
// Playfield geometry, screen timing limits, the RGB332 cell type and the
// background colour used outside the playfield.
package grid_video_pkg;

    localparam int unsigned GRID_COLS  = 10;
    localparam int unsigned GRID_ROWS  = 20;
    localparam int unsigned CELLS      = GRID_COLS * GRID_ROWS;
    localparam int unsigned CELL_PX    = 16;
    localparam int unsigned CELL_SHIFT = 4;    // log2(CELL_PX)
    localparam int unsigned X_OFF      = 240;
    localparam int unsigned Y_OFF      = 80;
    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;

    typedef logic [7:0] cell_t;       // RGB332, 0 = empty
    typedef logic [7:0] cell_addr_t;  // row*GRID_COLS+col
    typedef logic [9:0] xpos_t;
    typedef logic [8:0] ypos_t;

    localparam cell_t BG_RGB = 8'h00;

endpackage

// File: rtl/grid_video_renderer_if.sv
// Game-logic port A and video signals of the grid video renderer.
//   px_en      active-video enable from the VGA timing block
//   wr_en      port-A write enable
//   wr_addr    port-A cell address
//   wr_data    port-A write data (RGB332)
//   rd_data    port-A registered read data
//   pixel_rgb  registered RGB332 pixel
// master: game controller / timing side, slave: the renderer.
interface grid_video_renderer_if;
    import grid_video_pkg::*;

    logic       px_en;
    logic       wr_en;
    cell_addr_t wr_addr;
    cell_t      wr_data;
    cell_t      rd_data;
    cell_t      pixel_rgb;

    modport master (
        output px_en, wr_en, wr_addr, wr_data,
        input  rd_data, pixel_rgb
    );

    modport slave (
        input  px_en, wr_en, wr_addr, wr_data,
        output rd_data, pixel_rgb
    );

endinterface

// File: rtl/grid_mem_dp.sv
// True dual-port 200x8 playfield RAM, both ports synchronous, 1-cycle latency.
//   clk, reset       clock; synchronous reset clears only the read registers
//   a_we/a_addr/a_wdata/a_q  game-logic port, read-first
//   b_addr/b_q       renderer read port
// Out-of-range addresses ignore writes and read as 0. A port-B read that
// collides with a port-A write returns the old contents.
module grid_mem_dp
    import grid_video_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       a_we,
    input  cell_addr_t a_addr,
    input  cell_t      a_wdata,
    output cell_t      a_q,
    input  cell_addr_t b_addr,
    output cell_t      b_q
);

    localparam cell_addr_t NUM_CELLS = cell_addr_t'(CELLS);

    cell_t mem [CELLS];

    always_ff @(posedge clk) begin
        if (a_we && (a_addr < NUM_CELLS)) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= (a_addr < NUM_CELLS) ? mem[a_addr] : '0;
            b_q <= (b_addr < NUM_CELLS) ? mem[b_addr] : '0;
        end
    end

endmodule

// File: rtl/grid_video_renderer.sv
// Renders the Tetris playfield as a raster of RGB332 pixels.
//   clk, reset  system clock, synchronous active-high reset
//   bus         slave side of grid_video_renderer_if (port A + video)
// A clk/2 phase toggle advances x while px_en is high; a falling px_en
// ends the line. Pixels pass a 3-register pipeline (address, RAM, output),
// so a pixel appears 2 clk after its x value.
module grid_video_renderer
    import grid_video_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    grid_video_renderer_if.slave         bus
);

    localparam xpos_t X_MAX = xpos_t'(H_ACTIVE - 1);
    localparam ypos_t Y_MAX = ypos_t'(V_ACTIVE - 1);
    localparam xpos_t X_LO  = xpos_t'(X_OFF);
    localparam xpos_t X_HI  = xpos_t'(X_OFF + GRID_COLS * CELL_PX);
    localparam ypos_t Y_LO  = ypos_t'(Y_OFF);
    localparam ypos_t Y_HI  = ypos_t'(Y_OFF + GRID_ROWS * CELL_PX);

    xpos_t      x_q, x_d;
    ypos_t      y_q, y_d;
    logic       phase_q, phase_d;
    logic       px_en_q;
    cell_addr_t addr_q, addr_d;
    logic       inside_q, inside2_q, in_field;
    cell_t      pixel_q;
    cell_t      q_b;
    xpos_t      x_rel, row_w;
    ypos_t      y_rel;

    grid_mem_dp u_mem (
        .clk     (clk),
        .reset   (reset),
        .a_we    (bus.wr_en),
        .a_addr  (bus.wr_addr),
        .a_wdata (bus.wr_data),
        .a_q     (bus.rd_data),
        .b_addr  (addr_q),
        .b_q     (q_b)
    );

    // Raster counters.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        if (px_en_q && !bus.px_en) begin
            x_d     = '0;
            phase_d = 1'b0;
            y_d     = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
        end else if (bus.px_en) begin
            phase_d = ~phase_q;
            if (phase_q && (x_q != X_MAX)) begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Cell address: row*10 + col as (row<<3)+(row<<1)+col, truncated to 8 bits.
    always_comb begin
        x_rel    = x_q - X_LO;
        y_rel    = y_q - Y_LO;
        row_w    = xpos_t'(y_rel >> CELL_SHIFT);
        in_field = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
        addr_d   = '0;
        if (in_field) begin
            addr_d = cell_addr_t'((row_w << 3) + (row_w << 1) + (x_rel >> CELL_SHIFT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            phase_q   <= 1'b0;
            px_en_q   <= 1'b0;
            addr_q    <= '0;
            inside_q  <= 1'b0;
            inside2_q <= 1'b0;
            pixel_q   <= BG_RGB;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            phase_q   <= phase_d;
            px_en_q   <= bus.px_en;
            addr_q    <= addr_d;
            inside_q  <= in_field && bus.px_en;
            inside2_q <= inside_q;  // aligns with q_b
            pixel_q   <= (bus.px_en && inside2_q) ? q_b : BG_RGB;
        end
    end

    assign bus.pixel_rgb = pixel_q;

endmodule

// File: tb/tb_grid_video_renderer.sv
// Directed, table-driven bench for grid_video_renderer.
// Uninteresting lines are run as very short px_en pulses so that the line
// counter can be stepped to any y cheaply; lines under test are run long
// enough to reach x>400, with every pixel captured per clock.
module tb_grid_video_renderer;
    import grid_video_pkg::*;

    localparam int LINE_CLKS = 820;

    logic clk = 1'b0;
    logic reset;
    grid_video_renderer_if bus ();

    grid_video_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          y;
        int          x;
        logic [7:0]  exp;
    } vec_t;

    vec_t       vecs [$];
    logic [7:0] cap [LINE_CLKS];
    int         cur_y;
    int         cap_y;
    int         passed;
    int         total;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    endtask

    task automatic short_line();
        bus.px_en = 1'b1;
        tick();
        tick();
        bus.px_en = 1'b0;
        tick();
        tick();
        cur_y = (cur_y + 1) % 480;
    endtask

    task automatic goto_line(input int y);
        while (cur_y != y) short_line();
    endtask

    // Pixel captured after edge p shows x = (p-2)/2; x is sampled at p = 2x+3.
    task automatic full_line();
        bus.px_en = 1'b1;
        for (int p = 0; p < LINE_CLKS; p++) begin
            tick();
            cap[p] = bus.pixel_rgb;
        end
        bus.px_en = 1'b0;
        tick();
        check($sformatf("blank after line y%0d", cur_y), bus.pixel_rgb, 8'h00);
        tick();
        tick();
        cap_y = cur_y;
        cur_y = (cur_y + 1) % 480;
    endtask

    task automatic write_cell(input int addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cur_y  = 0;
        cap_y  = -1;
        reset       = 1'b1;
        bus.px_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        tick();
        reset = 1'b0;
        check("reset pixel_rgb", bus.pixel_rgb, 8'h00);
        check("reset rd_data", bus.rd_data, 8'h00);

        // Preload the whole playfield with empty cells.
        for (int a = 0; a < 200; a++) write_cell(a, 8'h00);

        // Read-first write, then readback.
        write_cell(1, 8'h01);
        check("write addr1 old value", bus.rd_data, 8'h00);
        bus.wr_addr = 8'd1;
        tick();
        check("read addr1", bus.rd_data, 8'h01);

        write_cell(199, 8'hE0);
        check("write addr199 old value", bus.rd_data, 8'h00);
        bus.wr_addr = 8'd199;
        tick();
        check("read addr199", bus.rd_data, 8'hE0);

        write_cell(10, 8'h1C);

        write_cell(200, 8'hFF);
        check("write addr200 read", bus.rd_data, 8'h00);
        bus.wr_addr = 8'd200;
        tick();
        check("read addr200", bus.rd_data, 8'h00);

        // Display vectors, sorted by line.
        vecs.push_back('{79,  256, 8'h00});
        vecs.push_back('{80,  239, 8'h00});
        vecs.push_back('{80,  240, 8'h00});
        vecs.push_back('{80,  255, 8'h00});
        vecs.push_back('{80,  256, 8'h01});
        vecs.push_back('{80,  263, 8'h01});
        vecs.push_back('{80,  271, 8'h01});
        vecs.push_back('{80,  272, 8'h00});
        vecs.push_back('{95,  240, 8'h00});
        vecs.push_back('{95,  264, 8'h01});
        vecs.push_back('{96,  240, 8'h1C});
        vecs.push_back('{96,  256, 8'h00});
        vecs.push_back('{384, 383, 8'h00});
        vecs.push_back('{384, 384, 8'hE0});
        vecs.push_back('{384, 399, 8'hE0});
        vecs.push_back('{384, 400, 8'h00});
        vecs.push_back('{399, 392, 8'hE0});
        vecs.push_back('{400, 384, 8'h00});

        foreach (vecs[i]) begin
            if (vecs[i].y != cap_y) begin
                goto_line(vecs[i].y);
                full_line();
            end
            check($sformatf("pixel y%0d x%0d", vecs[i].y, vecs[i].x),
                  cap[2 * vecs[i].x + 3], vecs[i].exp);
        end

        // Wrap y back round to 0 and on to line 85, then reset near x=300.
        goto_line(85);
        bus.px_en = 1'b1;
        for (int p = 0; p < 603; p++) begin
            tick();
            cap[p] = bus.pixel_rgb;
        end
        check("pre-reset pixel y85 x256", cap[2 * 256 + 3], 8'h01);
        reset = 1'b1;
        tick();
        check("mid-line reset pixel", bus.pixel_rgb, 8'h00);
        reset     = 1'b0;
        bus.px_en = 1'b0;
        tick();
        check("post-reset blank pixel", bus.pixel_rgb, 8'h00);
        cur_y = 0;
        cap_y = -1;

        // y must restart at 0: line 80 counted from the reset shows cell 1.
        goto_line(80);
        full_line();
        check("after reset y80 x260", cap[2 * 260 + 3], 8'h01);
        check("after reset y80 x244", cap[2 * 244 + 3], 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/grid_video_renderer.md
Name: grid_video_renderer

Overview:
- Stores the Tetris playfield in a dual-port grid memory.
- Converts the playfield into a raster stream of 8-bit RGB pixels for the VGA output stage.
- Port A is the game-logic read/write port; port B is read internally by the renderer.
- Sits between the game controller (writer) and the VGA timing/DAC block, which supplies the active-video enable.

Parameters:
GRID_COLS, 10, playfield columns
GRID_ROWS, 20, playfield rows (200 cells, addresses 0..199)
CELL_PX, 16, cell edge length in pixels
X_OFF, 240, first playfield pixel column
Y_OFF, 80, first playfield line
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
BG_RGB, 8'h00, colour outside the playfield

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
px_en  in  1  active-video enable from VGA timing; high for a whole visible line, low during blanking
wr_en  in  1  port-A write enable
wr_addr  in  8  port-A cell address, row*GRID_COLS+col
wr_data  in  8  port-A cell value, RGB332; 0 = empty
rd_data  out  8  port-A registered read data
pixel_rgb  out  8  registered RGB332 pixel

Behaviour:
- Memory: 200x8, contents undefined at power-up and not cleared by reset. Both ports synchronous with 1-cycle read latency.
- Port A is read-first: on a write, rd_data shows the old value and the new value is visible on the next read.
- Port-A addresses >=200: writes are ignored and reads return 0.
- Port-B collision with a port-A write to the same address in the same cycle returns the old value.
- Reset (synchronous) clears rd_data, pixel_rgb, x, y, the pixel-phase toggle and the px_en edge register to 0. Reset mid-frame restarts at x=0, y=0.
- Pixel clock: a phase toggle runs at clk/2 while px_en=1. x increments on the phase=1 cycle and saturates at H_ACTIVE-1.
- Line advance: on a px_en falling edge, x←0 and phase←0. y increments, wrapping from V_ACTIVE-1 to 0.
- While px_en=0, pixel_rgb = BG_RGB.
- Playfield test: X_OFF <= x < X_OFF+GRID_COLS*CELL_PX and Y_OFF <= y < Y_OFF+GRID_ROWS*CELL_PX.
  - col = (x-X_OFF)/CELL_PX, row = (y-Y_OFF)/CELL_PX (shift, since CELL_PX is a power of 2).
  - Port-B addr = row*GRID_COLS+col, computed as (row<<3)+(row<<1)+col in 8 bits.
- Pipeline: cycle 0 registers the address and an inside flag; cycle 1 gives memory q_b; cycle 2 sets pixel_rgb = inside ? q_b : BG_RGB. A pixel appears 2 clk after its x value; the two-clock pixel period hides this.
- An empty cell (0) renders black, which is identical to BG_RGB.

Decomposition:
- Shared package grid_video_pkg holds GRID_COLS, GRID_ROWS, CELL_PX, H_ACTIVE, V_ACTIVE, the cell type (8-bit RGB332) and the BG_RGB constant.
- One sub-module, grid_mem_dp: true dual-port 200x8 synchronous RAM with a q-register reset. The top level holds the counters, address generation and output pipeline.

Test Plan:
- Reset held 1 cycle, then px_en=0 → pixel_rgb=0x00, rd_data=0x00, x=y=0.
- Write 0x01 to addr 1, then read addr 1 with wr_en=0 → rd_data=0x01 one clk later. Read during the write cycle returns the prior value.
- After the addr-1 write, raise px_en for 25.4 µs then drop it for 300 ns, repeated 96 lines:
  - pixels x 256..271 on lines 80..95 → pixel_rgb=0x01.
  - x 240..255 (addr 0, never written, preloaded 0) → 0x00.
- Write 0xE0 to addr 199 → pixels x 384..399, y 384..399 output 0xE0. x=400 and y=400 → BG_RGB.
- Write to addr 200 with 0xFF, then read addr 200 → rd_data=0x00, no effect on the display.
- Assert reset mid-line (y=85, x=300) → next cycle x=0, y=0, pixel_rgb=0x00. Rendering resumes correctly on the next px_en-high line.
